fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The fetch_unit SHALL use one clock; reset is asynchronous and active-low. Ports clk, rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 nextPC  in  16  next fetch address from the PC-select logic (its readAdd); sampled only on PC load.
REQ-005 stall  in  1  decode cannot accept; IF/ID register holds.
REQ-006 flush  in  1  squash IF/ID contents and any outstanding fetch; load nextPC.
REQ-007 halt  in  1  decoded HALT; fetch stops permanently until reset.
REQ-008 imemReq  out  1  instruction-memory request, held until imemRdy or abort.
REQ-009 imemAddr  out  16  fetch address; equals pcCurrent; stable while imemReq=1.
REQ-010 imemRdy  in  1  memory completion; data valid this cycle; ignored when imemReq=0.
REQ-011 imemData  in  16  fetched instruction.
REQ-012 pcCurrent  out  16  PC register; feeds the PC-select logic.
REQ-013 instr  out  16  IF/ID instruction register.
REQ-014 ifValid  out  1  instr holds a live instruction.
REQ-015 err  out  1  sticky fault: misaligned PC or memory timeout.

Function
REQ-016 States SHALL be IDLE, BUSY, HALT.
REQ-017 IDLE: imemReq=0; next state unconditionally BUSY.
REQ-018 BUSY: imemReq=1 iff !(ifValid & stall) and !flush; otherwise 0 (abort/hold).
REQ-019 In BUSY, imemReq=1 & imemRdy SHALL, next edge: instr<=imemData, ifValid<=1, pcCurrent<=nextPC; one-cycle minimum fetch latency.
REQ-020 If ifValid=1 & stall=0 and no capture occurs this cycle, ifValid SHALL clear (instruction consumed).
REQ-021 If ifValid=1 & stall=1, instr and ifValid SHALL hold, and pcCurrent SHALL hold.
REQ-022 flush=1 (any state except HALT) SHALL, next edge: ifValid<=0, pcCurrent<=nextPC, wait counter<=0, state BUSY; same-cycle imemRdy discarded.
REQ-023 Priority: rst > flush > halt > capture > stall.
REQ-024 halt=1 with flush=0 SHALL move to HALT next edge; an imemRdy the same cycle is discarded; HALT drives imemReq=0, freezes pcCurrent, clears ifValid once consumed (stall=0); exit only by reset.
REQ-025 A wait counter (5 bits) SHALL count consecutive BUSY cycles with imemReq=1 & imemRdy=0; reset on capture, abort, or flush.
REQ-026 Counter reaching 16 SHALL set err and enter HALT next edge.
REQ-027 PC load with nextPC[0]=1 SHALL set err and enter HALT; pcCurrent loads the value anyway (for debug).
REQ-028 pcCurrent arithmetic is external; 16'hFFFE -> 16'h0000 wrap accepted without error.
REQ-029 err SHALL clear only by reset.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, pcCurrent=16'h0000, instr=16'h0800 (NOP), ifValid=0, err=0, counter=0, imemReq=0.
REQ-031 Reset assertion mid-fetch SHALL abort the request asynchronously; first request issued the second edge after rst rises.

Structure
REQ-032 Shared package SHALL hold the state encoding, NOP_INSTR=16'h0800, IMEM_TIMEOUT=16, RESET_PC=16'h0000.
REQ-033 One sub-module SHALL be used: reg16_en (16-bit enable register, async active-low reset, parameterised reset value) for pcCurrent and instr.

Verification
REQ-034 Reset release, imemRdy tied 1, nextPC=pcCurrent+2 -> imemAddr 0,2,4,6 on consecutive cycles; ifValid=1 from cycle 3.
REQ-035 imemRdy delayed 3 cycles at addr 0x0010 -> imemReq/imemAddr held 0x0010 for 4 cycles; instr updated once.
REQ-036 ifValid=1, stall=1 for 5 cycles -> instr, pcCurrent, imemReq=0 constant; fetch resumes the cycle stall drops.
REQ-037 flush with nextPC=0x0100 concurrent with imemRdy -> response dropped, ifValid=0, next imemAddr=0x0100.
REQ-038 imemRdy held 0 for 16 cycles -> err=1, state HALT, imemReq=0; likewise nextPC=0x0003 load -> err=1.
REQ-039 halt=1 then rst pulsed low mid-HALT -> all outputs at reset values immediately; fetch restarts at 0x0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared encodings and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INSTR    = 16'h0800;
    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam int          IMEM_TIMEOUT = 16;

endpackage

// File: rtl/fetch_unit_reg16_en.sv
// 16-bit load-enable register with async active-low reset to a parameterised value.
module reg16_en #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, memory handshake, IF/ID register, fault detection.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nextPC,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemRdy,
    input  logic [15:0] imemData,
    output logic [15:0] pcCurrent,
    output logic [15:0] instr,
    output logic        ifValid,
    output logic        err
);

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        vld_nxt;
    logic        pc_ld, cap, fault;

    reg16_en #(.RST_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_ld),
        .d   (nextPC),
        .q   (pcCurrent)
    );

    reg16_en #(.RST_VAL(NOP_INSTR)) u_instr (
        .clk (clk),
        .rst (rst),
        .en  (cap),
        .d   (imemData),
        .q   (instr)
    );

    assign imemAddr = pcCurrent;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ifValid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ifValid <= vld_nxt;
            err     <= err | fault;
        end
    end

    // Flush beats halt beats capture; a held (stalled) instruction suppresses new requests.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vld_nxt   = ifValid;
        pc_ld     = 1'b0;
        cap       = 1'b0;
        fault     = 1'b0;
        case (state)
            ST_IDLE, ST_BUSY: begin
                state_nxt = ST_BUSY;
                if (ifValid && !stall) vld_nxt = 1'b0;
                if (flush) begin
                    pc_ld   = 1'b1;
                    vld_nxt = 1'b0;
                    cnt_nxt = '0;
                end else if (halt) begin
                    state_nxt = ST_HALT;
                    cnt_nxt   = '0;
                end else if (imemReq && imemRdy) begin
                    cap     = 1'b1;
                    pc_ld   = 1'b1;
                    vld_nxt = 1'b1;
                    cnt_nxt = '0;
                end else if (imemReq) begin
                    cnt_nxt = cnt + 5'd1;
                    if (cnt_nxt == 5'(IMEM_TIMEOUT)) begin
                        fault     = 1'b1;
                        state_nxt = ST_HALT;
                    end
                end else begin
                    cnt_nxt = '0;
                end
                // Misaligned target still loads so the bad PC is visible for debug.
                if (pc_ld && nextPC[0]) begin
                    fault     = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (ifValid && !stall) vld_nxt = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imemReq = 1'b0;
        if (state == ST_BUSY)
            imemReq = !(ifValid && stall) && !flush;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] nextPC = '0;
    logic        stall = 1'b0, flush = 1'b0, halt = 1'b0;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemRdy = 1'b0;
    logic [15:0] imemData = '0;
    logic [15:0] pcCurrent, instr;
    logic        ifValid, err;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .nextPC    (nextPC),
        .stall     (stall),
        .flush     (flush),
        .halt      (halt),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemRdy   (imemRdy),
        .imemData  (imemData),
        .pcCurrent (pcCurrent),
        .instr     (instr),
        .ifValid   (ifValid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // reference model: phase 0 = waiting to start, 1 = fetching, 2 = stopped
    int          m_phase;
    logic [15:0] m_pc, m_instr;
    bit          m_vld, m_err;
    int          m_wait;

    function automatic bit m_req();
        return (m_phase == 1) && !(m_vld && stall) && !flush;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_pc = 16'h0000; m_instr = 16'h0800;
        m_vld = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic m_edge();
        bit req, consumed;
        req      = m_req();
        consumed = m_vld && !stall;
        if (m_phase == 2) begin
            if (consumed) m_vld = 0;
        end else if (flush) begin
            m_pc = nextPC; m_vld = 0; m_wait = 0; m_phase = 1;
            if (nextPC[0]) begin m_err = 1; m_phase = 2; end
        end else if (halt) begin
            if (consumed) m_vld = 0;
            m_wait = 0; m_phase = 2;
        end else if (req && imemRdy) begin
            m_instr = imemData; m_pc = nextPC; m_vld = 1; m_wait = 0; m_phase = 1;
            if (nextPC[0]) begin m_err = 1; m_phase = 2; end
        end else begin
            if (consumed) m_vld = 0;
            m_phase = 1;
            if (req) begin
                m_wait++;
                if (m_wait >= 16) begin m_err = 1; m_phase = 2; end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        chk("imemReq",   16'(imemReq),  16'(m_req()));
        chk("imemAddr",  imemAddr,      m_pc);
        chk("pcCurrent", pcCurrent,     m_pc);
        chk("instr",     instr,         m_instr);
        chk("ifValid",   16'(ifValid),  16'(m_vld));
        chk("err",       16'(err),      16'(m_err));
    endtask

    // Asserts reset mid-cycle and checks the outputs collapse before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        m_reset();
        chk("rst_req",   16'(imemReq), 16'h0000);
        chk("rst_pc",    pcCurrent,    16'h0000);
        chk("rst_instr", instr,        16'h0800);
        chk("rst_vld",   16'(ifValid), 16'h0000);
        chk("rst_err",   16'(err),     16'h0000);
        stall = 0; flush = 0; halt = 0; imemRdy = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int rdy_pct, stall_pct, flush_pct, halt_pct, odd_pct, cycles;
    } phase_t;

    phase_t phases[7];

    initial begin
        phases[0] = '{100,  0,  0, 0,  0, 10};  // back-to-back fetch
        phases[1] = '{ 40, 30,  0, 0,  0, 60};  // slow memory, stalls
        phases[2] = '{ 70, 20, 10, 0,  0, 60};  // flushes
        phases[3] = '{  0,  0,  0, 0,  0, 25};  // memory timeout
        phases[4] = '{ 80, 10,  0, 0, 10, 40};  // misaligned targets
        phases[5] = '{ 60, 20,  0, 5,  0, 40};  // halt
        phases[6] = '{ 50, 25,  8, 3,  3, 80};  // mixed

        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 7; p++) begin
                do_reset();
                for (int c = 0; c < phases[p].cycles; c++) begin
                    imemRdy  = ($urandom_range(99) < phases[p].rdy_pct);
                    stall    = ($urandom_range(99) < phases[p].stall_pct);
                    flush    = ($urandom_range(99) < phases[p].flush_pct);
                    halt     = ($urandom_range(99) < phases[p].halt_pct);
                    imemData = 16'($urandom);
                    if (flush) nextPC = 16'($urandom) & 16'hFFFE;
                    else       nextPC = m_pc + 16'd2;
                    if ($urandom_range(99) < phases[p].odd_pct) nextPC[0] = 1'b1;
                    #1;
                    check_outputs();
                    @(posedge clk);
                    m_edge();
                    @(negedge clk);
                end
            end
        end

        // wrap from 0xFFFE to 0x0000 is an ordinary load
        do_reset();
        stall = 0; imemRdy = 1; nextPC = 16'hFFFE;
        flush = 1;
        #1; check_outputs();
        @(posedge clk); m_edge(); @(negedge clk);
        flush = 0;
        for (int c = 0; c < 4; c++) begin
            nextPC = m_pc + 16'd2;
            imemData = 16'($urandom);
            #1; check_outputs();
            @(posedge clk); m_edge(); @(negedge clk);
        end
        #1; check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
